// File: rtl/oem_pixel_writer.sv
// oem_pixel_writer
// Deserializes the transmitter's serial stream into 8-bit pixels (MSB first)
// for a 16x16 image and writes each pixel into one of eight 32-entry
// odd/even memories, chosen by checkerboard parity and image quarter.
// When the stream ends, missing pixels are written as zero and oem_finish
// is raised until reset.
module oem_pixel_writer (
   input  logic       clk,
   input  logic       reset,
   input  logic       so_data,
   input  logic       so_valid,
   input  logic       pi_end,
   output logic [4:0] oem_addr,
   output logic [7:0] oem_dataout,
   output logic       odd1_wr,
   output logic       odd2_wr,
   output logic       odd3_wr,
   output logic       odd4_wr,
   output logic       even1_wr,
   output logic       even2_wr,
   output logic       even3_wr,
   output logic       even4_wr,
   output logic       oem_finish
);

   localparam logic [1:0] StCollect = 2'd0;
   localparam logic [1:0] StFlush   = 2'd1;
   localparam logic [1:0] StFill    = 2'd2;
   localparam logic [1:0] StDone    = 2'd3;

   logic [1:0] state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [2:0] bitCnt_q, bitCnt_d;
   logic [8:0] pix_q, pix_d;
   logic       full_q, full_d;
   logic       validPrev_q, validPrev_d;
   logic [4:0] addr_q, addr_d;
   logic [7:0] data_q, data_d;
   logic [7:0] wr_q, wr_d;
   logic       finish_q, finish_d;

   logic       doWrite;
   logic [7:0] wrData;
   logic [2:0] alignAmt;
   logic [2:0] memSel;

   // Left-align a partial byte: shift by 8 - bitCnt (bitCnt is 1..7 here).
   assign alignAmt = 3'd0 - bitCnt_q;

   // Memory select: odd group when parity is 1 (strobe bits 0..3), even group
   // otherwise (strobe bits 4..7); the image quarter picks the memory within.
   assign memSel = {~(pix_q[0] ^ pix_q[4]), pix_q[7:6]};

   // Next-state logic: byte assembly, end detection, flush and zero fill.
   // A completed byte is written one edge after its 8th bit via full_q.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      bitCnt_d    = bitCnt_q;
      pix_d       = pix_q;
      full_d      = full_q;
      validPrev_d = so_valid;
      addr_d      = addr_q;
      data_d      = data_q;
      wr_d        = 8'd0;
      finish_d    = finish_q;
      doWrite     = 1'b0;
      wrData      = 8'd0;

      case (state_q)
         StCollect: begin
            if (full_q) begin
               full_d = 1'b0;
               if (!pix_q[8]) begin
                  doWrite = 1'b1;
                  wrData  = shift_q;
               end
            end
            if (so_valid) begin
               shift_d  = {shift_q[6:0], so_data};
               bitCnt_d = bitCnt_q + 3'd1;
               if (bitCnt_q == 3'd7) begin
                  full_d = 1'b1;
               end
            end
            if (validPrev_q && !so_valid && pi_end) begin
               state_d = StFlush;
            end
         end
         StFlush: begin
            if ((bitCnt_q != 3'd0) && !pix_q[8]) begin
               doWrite = 1'b1;
               wrData  = shift_q << alignAmt;
            end
            bitCnt_d = 3'd0;
            state_d  = StFill;
         end
         StFill: begin
            if (!pix_q[8]) begin
               doWrite = 1'b1;
               wrData  = 8'd0;
            end else begin
               state_d  = StDone;
               finish_d = 1'b1;
            end
         end
         default: begin
            state_d = StDone;
         end
      endcase

      if (doWrite) begin
         pix_d  = pix_q + 9'd1;
         addr_d = pix_q[5:1];
         data_d = wrData;
         wr_d   = 8'd1 << memSel;
      end
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StCollect;
         shift_q     <= 8'd0;
         bitCnt_q    <= 3'd0;
         pix_q       <= 9'd0;
         full_q      <= 1'b0;
         validPrev_q <= 1'b0;
         addr_q      <= 5'd0;
         data_q      <= 8'd0;
         wr_q        <= 8'd0;
         finish_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         bitCnt_q    <= bitCnt_d;
         pix_q       <= pix_d;
         full_q      <= full_d;
         validPrev_q <= validPrev_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         wr_q        <= wr_d;
         finish_q    <= finish_d;
      end
   end

   assign oem_addr    = addr_q;
   assign oem_dataout = data_q;
   assign odd1_wr     = wr_q[0];
   assign odd2_wr     = wr_q[1];
   assign odd3_wr     = wr_q[2];
   assign odd4_wr     = wr_q[3];
   assign even1_wr    = wr_q[4];
   assign even2_wr    = wr_q[5];
   assign even3_wr    = wr_q[6];
   assign even4_wr    = wr_q[7];
   assign oem_finish  = finish_q;

endmodule

// File: tb/tb_oem_pixel_writer.sv
// tb_oem_pixel_writer
// Directed bench for oem_pixel_writer: every write strobe is logged with its
// address, data and cycle, and the log is compared against hand-derived
// expectations after each scenario.
module tb_oem_pixel_writer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       so_data = 1'b0;
   logic       so_valid = 1'b0;
   logic       pi_end = 1'b0;
   logic [4:0] oem_addr;
   logic [7:0] oem_dataout;
   logic       odd1_wr, odd2_wr, odd3_wr, odd4_wr;
   logic       even1_wr, even2_wr, even3_wr, even4_wr;
   logic       oem_finish;
   logic [7:0] strobes;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int finishCyc = -1;

   logic [7:0] logStb[$];
   logic [4:0] logAddr[$];
   logic [7:0] logData[$];
   int         logCyc[$];

   oem_pixel_writer dut (
      .clk        (clk),
      .reset      (reset),
      .so_data    (so_data),
      .so_valid   (so_valid),
      .pi_end     (pi_end),
      .oem_addr   (oem_addr),
      .oem_dataout(oem_dataout),
      .odd1_wr    (odd1_wr),
      .odd2_wr    (odd2_wr),
      .odd3_wr    (odd3_wr),
      .odd4_wr    (odd4_wr),
      .even1_wr   (even1_wr),
      .even2_wr   (even2_wr),
      .even3_wr   (even3_wr),
      .even4_wr   (even4_wr),
      .oem_finish (oem_finish)
   );

   assign strobes = {even4_wr, even3_wr, even2_wr, even1_wr,
                     odd4_wr, odd3_wr, odd2_wr, odd1_wr};

   // 10 ns clock.
   always #5 clk = ~clk;

   // Cycle counter: value equals the index of the most recent rising edge.
   always @(posedge clk) cyc <= cyc + 1;

   // Log every write cycle and the first cycle oem_finish is seen high.
   always @(negedge clk) begin
      if (strobes != 8'd0) begin
         logStb.push_back(strobes);
         logAddr.push_back(oem_addr);
         logData.push_back(oem_dataout);
         logCyc.push_back(cyc);
      end
      if (oem_finish && finishCyc < 0) finishCyc = cyc;
   end

   // Overall time limit so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic d, input logic pe);
      so_valid = v;
      so_data  = d;
      pi_end   = pe;
      @(posedge clk);
      #1;
   endtask

   task automatic sendByte(input logic [7:0] b, input logic pe);
      for (int i = 7; i >= 0; i--) applyStimulus(1'b1, b[i], pe);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic clearLog();
      logStb.delete();
      logAddr.delete();
      logData.delete();
      logCyc.delete();
      finishCyc = -1;
   endtask

   task automatic applyReset();
      so_valid = 1'b0;
      so_data  = 1'b0;
      pi_end   = 1'b0;
      reset    = 1'b0;
      #2;
      checkOutput("reset_outputs", {18'd0, oem_addr, oem_dataout, strobes, oem_finish}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      clearLog();
   endtask

   task automatic waitFinish(input int maxCycles);
      int n = 0;
      while (!oem_finish && n < maxCycles) begin
         applyStimulus(1'b0, 1'b0, 1'b0);
         n++;
      end
      if (!oem_finish) checkOutput("finish_timeout", 32'd0, 32'd1);
   endtask

   // Compare one log entry; expCyc < 0 means timing is not checked.
   task automatic checkEntry(input string tag, input int idx, input logic [7:0] expStb,
                             input logic [4:0] expAddr, input logic [7:0] expData, input int expCyc);
      if (idx >= logStb.size()) begin
         checkOutput({tag, "_missing"}, logStb.size(), idx + 1);
      end else begin
         checkOutput({tag, "_strobe"}, {24'd0, logStb[idx]}, {24'd0, expStb});
         checkOutput({tag, "_addr"}, {27'd0, logAddr[idx]}, {27'd0, expAddr});
         checkOutput({tag, "_data"}, {24'd0, logData[idx]}, {24'd0, expData});
         if (expCyc >= 0) checkOutput({tag, "_cycle"}, logCyc[idx], expCyc);
      end
   endtask

   // Strobe vector for pixel p: odd group on bits 0..3, even on 4..7.
   function automatic logic [7:0] expStrobe(input int p);
      logic [7:0] pv;
      int bank;
      pv   = 8'(p);
      bank = int'(pv[7:6]);
      if (pv[0] ^ pv[4]) return 8'd1 << bank;
      return 8'd1 << (bank + 4);
   endfunction

   function automatic logic [7:0] byteOf(input int i);
      if (i == 1) return 8'h3C;
      return 8'(i * 29 + 5);
   endfunction

   initial begin
      int c8;
      int ef;
      int bad;
      int once;
      int hits[256];
      logic [7:0] pv;

      #3;
      // Reset state and a single byte 0xA5.
      applyReset();
      sendByte(8'hA5, 1'b0);
      c8 = cyc;
      checkOutput("no_strobe_on_8th_bit", {24'd0, strobes}, 32'd0);
      idle(3);
      checkOutput("single_write_count", logStb.size(), 1);
      checkEntry("pix0_a5", 0, 8'b0001_0000, 5'd0, 8'hA5, c8 + 1);

      // Back-to-back bytes: routing of pixels 1, 16, 17, 64.
      applyReset();
      for (int i = 0; i < 65; i++) sendByte(byteOf(i), 1'b0);
      idle(3);
      checkOutput("b2b_write_count", logStb.size(), 65);
      checkEntry("pix1", 1, 8'b0000_0001, 5'd0, 8'h3C, -1);
      checkEntry("pix16", 16, 8'b0000_0001, 5'd8, byteOf(16), -1);
      checkEntry("pix17", 17, 8'b0001_0000, 5'd8, byteOf(17), -1);
      checkEntry("pix64", 64, 8'b0010_0000, 5'd0, byteOf(64), -1);
      if (logCyc.size() > 17) checkOutput("b2b_spacing", logCyc[17] - logCyc[16], 8);

      // Full image, pi_end high for the final 16 bits.
      applyReset();
      for (int i = 0; i < 256; i++) sendByte(byteOf(i), (i >= 254));
      applyStimulus(1'b0, 1'b0, 1'b1);
      ef = cyc;
      checkOutput("full_finish_low_at_fall", {31'd0, oem_finish}, 32'd0);
      idle(4);
      checkOutput("full_finish_cycle", finishCyc, ef + 2);
      checkOutput("full_write_count", logStb.size(), 256);
      bad = 0;
      for (int k = 0; k < 256; k++) hits[k] = 0;
      for (int i = 0; i < logStb.size(); i++) begin
         pv = 8'(i);
         if (logStb[i] != expStrobe(i) || logAddr[i] != pv[5:1] || logData[i] != byteOf(i)) bad++;
         for (int m = 0; m < 8; m++) if (logStb[i][m]) hits[m * 32 + int'(logAddr[i])]++;
      end
      checkOutput("full_entry_mismatches", bad, 0);
      once = 0;
      for (int k = 0; k < 256; k++) if (hits[k] == 1) once++;
      checkOutput("full_addr_coverage", once, 256);
      sendByte(8'hFF, 1'b0);
      idle(3);
      checkOutput("done_ignores_input", logStb.size(), 256);
      checkOutput("done_finish_held", {31'd0, oem_finish}, 32'd1);

      // Short stream: 13 bits, flush of a partial byte, then zero fill.
      applyReset();
      sendByte(8'hF0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      ef = cyc;
      waitFinish(400);
      idle(2);
      checkOutput("short_write_count", logStb.size(), 256);
      checkEntry("short_pix0", 0, 8'b0001_0000, 5'd0, 8'hF0, -1);
      checkEntry("short_flush", 1, 8'b0000_0001, 5'd0, 8'hB8, ef + 1);
      bad = 0;
      for (int i = 2; i < logStb.size(); i++) begin
         pv = 8'(i);
         if (logStb[i] != expStrobe(i) || logAddr[i] != pv[5:1] || logData[i] != 8'h00 ||
             logCyc[i] != logCyc[i - 1] + 1) bad++;
      end
      checkOutput("fill_entry_mismatches", bad, 0);
      if (logCyc.size() == 256) checkOutput("fill_finish_cycle", finishCyc, logCyc[255] + 1);

      // Gapped bits of 0x5A.
      applyReset();
      c8 = 0;
      for (int i = 7; i >= 0; i--) begin
         pv = 8'h5A;
         applyStimulus(1'b1, pv[i], 1'b0);
         c8 = cyc;
         idle(3);
      end
      checkOutput("gap_write_count", logStb.size(), 1);
      checkEntry("gap_5a", 0, 8'b0001_0000, 5'd0, 8'h5A, c8 + 1);

      // Reset mid-byte, then 0xFF starts again at pixel 0.
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0);
      applyReset();
      sendByte(8'hFF, 1'b0);
      idle(3);
      checkOutput("post_reset_count", logStb.size(), 1);
      checkEntry("post_reset_ff", 0, 8'b0001_0000, 5'd0, 8'hFF, -1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
